hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 42 ++++
 rtl/hazard_ctrl_sat_counter.sv | 36 +++
 rtl/hazard_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_ctrl_pkg : shared FSM encodings, defaults and hazard helpers
// Revision: 1.0
// ---------------------------------------------------------------------------
package hazard_ctrl_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR      = 2'd2;

  localparam int TIMEOUT_DEFAULT = 16;
  localparam int CNT_W_DEFAULT   = 32;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_stall;
    logic ex_mem_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_flush;
    logic pc_redirect;
  } ctrl_t;

  // x0 is hardwired, so a load to it can never create a dependency.
  function automatic logic f_load_use(
    input logic [4:0] rs1_addr,
    input logic [4:0] rs2_addr,
    input logic       rs1_used,
    input logic       rs2_used,
    input logic [4:0] rd_addr,
    input logic       reg_enable,
    input logic       mem_re
  );
    return mem_re && reg_enable && (rd_addr != 5'd0) &&
           ((rs1_used && (rs1_addr == rd_addr)) ||
            (rs2_used && (rs2_addr == rd_addr)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sat_counter : up-counter that sticks at all-ones instead of wrapping
// Revision: 1.0
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (inc && (q_q != '1)) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_ctrl : pipeline stall/flush/redirect control with memory timeout
// Revision: 1.0
// ---------------------------------------------------------------------------
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_reg_enable,
  input  logic             ex_mem_re,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             err_clr,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             pc_redirect,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // TIMEOUT must be at least 2 for the wait counter to reach its limit.
  localparam int                WAIT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_inc;
  logic              mem_wait;
  logic              load_use;
  ctrl_t             ctrl;

  always_comb begin
    mem_wait = dmem_req && !dmem_ready && (state_q != ST_ERR);
    load_use = f_load_use(id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
                          ex_rd_addr, ex_reg_enable, ex_mem_re);
    ctrl = '0;
    if (!reset) begin
      ctrl = '0;
    end else if (mem_wait) begin
      ctrl.pc_stall     = 1'b1;
      ctrl.if_id_stall  = 1'b1;
      ctrl.id_ex_stall  = 1'b1;
      ctrl.ex_mem_stall = 1'b1;
      ctrl.mem_wb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      // The ID instruction is wrong-path, so its load-use stall is moot.
      ctrl.pc_redirect  = 1'b1;
      ctrl.if_id_flush  = 1'b1;
      ctrl.id_ex_flush  = 1'b1;
    end else if (load_use) begin
      ctrl.pc_stall     = 1'b1;
      ctrl.if_id_stall  = 1'b1;
      ctrl.id_ex_flush  = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    wait_cnt_inc = wait_cnt_q + 1'b1;
    case (state_q)
      ST_RUN: begin
        if (mem_wait) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_wait) begin
          state_d = ST_RUN;
        end else begin
          wait_cnt_d = wait_cnt_inc;
          if (wait_cnt_inc == WAIT_LAST) begin
            state_d = ST_ERR;
          end
        end
      end
      ST_ERR: begin
        if (err_clr) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign pc_stall     = ctrl.pc_stall;
  assign if_id_stall  = ctrl.if_id_stall;
  assign id_ex_stall  = ctrl.id_ex_stall;
  assign ex_mem_stall = ctrl.ex_mem_stall;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign mem_wb_flush = ctrl.mem_wb_flush;
  assign pc_redirect  = ctrl.pc_redirect;
  assign bus_err      = (state_q == ST_ERR);

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ctrl.pc_stall),
    .q     (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ctrl.if_id_flush | ctrl.id_ex_flush | ctrl.mem_wb_flush),
    .q     (flush_cnt)
  );

endmodule
`default_nettype wire
